// File: rtl/th_imem.sv
// Instruction-memory responder for the threaded TTA fetch path: loader-filled word array,
// in-order read responses. Define TH_IMEM_WAITSTATE_EN to add the IDLE/WAIT/RESP wait-state engine.
module th_imem #(
  parameter int ADDRESS = 10,
  parameter int MEMBITS = 4,
  parameter int WIDTH   = 32,
  parameter int WAIT    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic               m_read_i,
  output logic               m_rack_o,
  input  logic [ADDRESS-1:0] m_addr_i,
  output logic               m_ready_o,
  output logic [WIDTH-1:0]   m_data_o,
  input  logic               ld_write_i,
  input  logic [MEMBITS-1:0] ld_addr_i,
  input  logic [WIDTH-1:0]   ld_data_i,
  output logic               busy_o
);

  localparam int DEPTH = 2 ** MEMBITS;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [MEMBITS-1:0] req_idx;

  // Upper request address bits alias onto the array; they are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^m_addr_i[ADDRESS-1:MEMBITS];
  assign req_idx        = m_addr_i[MEMBITS-1:0];

  // NOTE: the array has no reset; contents are defined only by loader writes.
  always_ff @(posedge clock) begin
    if (ld_write_i) mem[ld_addr_i] <= ld_data_i;
  end

`ifdef TH_IMEM_WAITSTATE_EN

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [MEMBITS-1:0] addr_q;
  logic [MEMBITS-1:0] rd_idx;
  logic               accept;
  logic               load_data;

  assign accept = m_read_i & enable_i & ~ld_write_i & reset_n & (state == S_IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      count  <= '0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        count  <= CNT_W'(WAIT);
        addr_q <= req_idx;
      end else if (state == S_WAIT) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // The counter reaches zero on the same edge that enters RESP.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (WAIT == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (count == CNT_W'(1)) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_rack_o  = accept;
    m_ready_o = (state == S_RESP);
    busy_o    = (state != S_IDLE);
  end

  // The array is read on the RESP-entry edge, so late loader writes to the latched address are returned.
  assign load_data = (state_next == S_RESP) && (state != S_RESP);
  assign rd_idx    = (state == S_IDLE) ? req_idx : addr_q;

  always_ff @(posedge clock) begin
    if (!reset_n)       m_data_o <= '0;
    else if (load_data) m_data_o <= mem[rd_idx];
  end

`else

  logic accept_q;

  // WAIT only matters when wait states are compiled in.
  logic [31:0] unused_wait;
  assign unused_wait = 32'(WAIT);

  assign m_rack_o = m_read_i & enable_i & ~ld_write_i & reset_n;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      accept_q <= 1'b0;
      m_data_o <= '0;
    end else begin
      accept_q <= m_rack_o;
      if (m_rack_o) m_data_o <= mem[req_idx];
    end
  end

  assign m_ready_o = accept_q;
  assign busy_o    = accept_q;

`endif

endmodule

// File: tb/tb_th_imem.sv
// Randomized self-checking bench for th_imem against an edge-numbered reference model.
// Covers both the zero-wait build and the TH_IMEM_WAITSTATE_EN build.
module tb_th_imem;

  localparam int ADDRESS = 10;
  localparam int MEMBITS = 4;
  localparam int WIDTH   = 32;
  localparam int WAIT_C  = 2;
  localparam int DEPTH   = 16;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               enable_i;
  logic               m_read_i;
  logic               m_rack_o;
  logic [ADDRESS-1:0] m_addr_i;
  logic               m_ready_o;
  logic [WIDTH-1:0]   m_data_o;
  logic               ld_write_i;
  logic [MEMBITS-1:0] ld_addr_i;
  logic [WIDTH-1:0]   ld_data_i;
  logic               busy_o;

  th_imem #(.ADDRESS(ADDRESS), .MEMBITS(MEMBITS), .WIDTH(WIDTH), .WAIT(WAIT_C)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable_i   (enable_i),
    .m_read_i   (m_read_i),
    .m_rack_o   (m_rack_o),
    .m_addr_i   (m_addr_i),
    .m_ready_o  (m_ready_o),
    .m_data_o   (m_data_o),
    .ld_write_i (ld_write_i),
    .ld_addr_i  (ld_addr_i),
    .ld_data_i  (ld_data_i),
    .busy_o     (busy_o)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: edges are numbered; a read accepted at edge A is returned in the
  // cycle after edge A+WAIT (wait build) or A (zero-wait build).
  logic [31:0] model_mem [DEPTH];
  bit          pend;
  int          acc_edge;
  int          paddr;
  int          edge_cnt;
  logic [31:0] exp_data;
  bit          exp_ready;
  bit          exp_busy;

  function automatic bit outstanding();
`ifdef TH_IMEM_WAITSTATE_EN
    return pend && (edge_cnt <= acc_edge + WAIT_C);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_rack();
    return reset_n && m_read_i && enable_i && !ld_write_i && !outstanding();
  endfunction

  function automatic void model_edge();
    bit acc;
    acc = exp_rack();
    edge_cnt++;
    if (!reset_n) begin
      pend      = 0;
      exp_ready = 0;
      exp_busy  = 0;
      exp_data  = '0;
    end else begin
`ifdef TH_IMEM_WAITSTATE_EN
      if (pend && edge_cnt > acc_edge + WAIT_C) pend = 0;
      if (acc) begin
        pend     = 1;
        acc_edge = edge_cnt;
        paddr    = int'(m_addr_i) % DEPTH;
      end
      exp_ready = pend && (edge_cnt == acc_edge + WAIT_C);
      exp_busy  = pend && (edge_cnt <= acc_edge + WAIT_C);
      if (exp_ready) exp_data = model_mem[paddr];
`else
      exp_ready = acc;
      exp_busy  = acc;
      if (acc) exp_data = model_mem[int'(m_addr_i) % DEPTH];
`endif
    end
    if (ld_write_i) model_mem[ld_addr_i] = ld_data_i;
  endfunction

  task automatic cycle(input logic rst, input logic rd, input logic en, input logic [9:0] addr,
                       input logic wr, input logic [3:0] waddr, input logic [31:0] wdata);
    @(negedge clock);
    check("ready", 32'(m_ready_o), 32'(exp_ready));
    check("data",  m_data_o,       exp_data);
    check("busy",  32'(busy_o),    32'(exp_busy));
    reset_n    = rst;
    m_read_i   = rd;
    enable_i   = en;
    m_addr_i   = addr;
    ld_write_i = wr;
    ld_addr_i  = waddr;
    ld_data_i  = wdata;
    #1;
    check("rack", 32'(m_rack_o), 32'(exp_rack()));
    @(posedge clock);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, '0, 1'b0, '0, '0);
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, '0, 1'b1, a, d);
  endtask

  task automatic read(input logic [9:0] a);
    cycle(1'b1, 1'b1, 1'b1, a, 1'b0, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0; m_read_i = 1'b1; enable_i = 1'b1; m_addr_i = '0;
    ld_write_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
    pend = 0; acc_edge = 0; paddr = 0; edge_cnt = 0;
    exp_data = '0; exp_ready = 0; exp_busy = 0;
    @(posedge clock);
    model_edge();
    // Reset state, with a read request held to confirm rack stays low.
    cycle(1'b0, 1'b1, 1'b1, 10'd2, 1'b0, '0, '0);

    for (int i = 0; i < DEPTH; i++) load(4'(i), 32'hA5A5_0000 | 32'(i));

    // Single read of a freshly loaded word.
    load(4'd0, 32'h0000_0000);
    load(4'd1, 32'h1000_0000);
    load(4'd2, 32'h1000_0000);
    load(4'd3, 32'h0000_0000);
    read(10'd2);
    idle(5);
    #1 check("single_read_word", m_data_o, 32'h1000_0000);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) read(10'(i));
    idle(6);

    // Held request: one accept per completed transaction.
    load(4'd9, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) read(10'd9);
    idle(6);
    #1 check("held_read_word", m_data_o, 32'hDEAD_BEEF);

    // Address wrap.
    load(4'd5, 32'h1234_5678);
    read(10'h3F5);
    idle(5);
    #1 check("wrap_word", m_data_o, 32'h1234_5678);

    // Loader collides with a read: write wins, the retried read sees the new word.
    cycle(1'b1, 1'b1, 1'b1, 10'd7, 1'b1, 4'd7, 32'hC0DE_0007);
    read(10'd7);
    idle(5);
    #1 check("collide_word", m_data_o, 32'hC0DE_0007);

    // Reset one cycle after an accept, then a normal read.
    read(10'd9);
    cycle(1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    idle(5);
    #1 check("after_reset_data", m_data_o, 32'h0000_0000);
    read(10'd1);
    idle(5);
    #1 check("post_reset_read", m_data_o, 32'h1000_0000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) != 0), ($urandom_range(9) < 7), ($urandom_range(19) < 17),
            10'($urandom), ($urandom_range(19) < 3), 4'($urandom), $urandom);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
